// File: rtl/codegen_pkg.sv
// Shared definitions for the stepped code generator and its receive-side checker.
// Holds the checker state encoding, the default code step and the next-code rule.
package codegen_pkg;

  // Checker FSM state encoding, visible on the state_o debug port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2,
    LOST   = 2'd3
  } state_e;

  // Increment per code word; generator and checker must agree on it.
  localparam int unsigned CODE_STEP = 73;

  // Widest code word the shared next-code function supports.
  localparam int unsigned MAX_W = 32;

  // next(x) = 0 when x equals limit, otherwise x + step wrapped modulo 2^width.
  function automatic logic [MAX_W-1:0] next_code(
    input logic [MAX_W-1:0] x,
    input logic [MAX_W-1:0] limit,
    input int unsigned      step,
    input int unsigned      width
  );
    logic [MAX_W-1:0] mask;
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    if (x == limit) begin
      return '0;
    end
    return (x + MAX_W'(step)) & mask;
  endfunction

endpackage

// File: rtl/codegen_next.sv
// Combinational next-code stage: next_o = next(x_i) for the given wrap limit.
// Shared between the code generator and the checker so both follow one rule.
module codegen_next
  import codegen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STEP       = CODE_STEP
) (
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] limit_i,
  output logic [DATA_WIDTH-1:0] next_o
);

  // Evaluate the shared next-code rule at this instance's word width.
  always_comb begin
    next_o = DATA_WIDTH'(next_code(MAX_W'(x_i), MAX_W'(limit_i), STEP, DATA_WIDTH));
  end

endmodule

// File: rtl/codecheck.sv
// Receive-side checker for the stepped code stream.
// Hunts for LOCK_CNT consecutive consistent words, then flywheels its own
// expected value, pulsing err_pulse and counting every mismatching word.
// LOSS_CNT consecutive misses drop lock for one LOST cycle before re-hunting.
// Optional build macro CODECHECK_ERR_CAPTURE_EN adds capture of the first
// mismatch (expected and received word) seen after lock is acquired.
module codecheck
  import codegen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STEP       = CODE_STEP,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned LOSS_CNT   = 3,
  parameter int unsigned ERR_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] limit,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [ERR_W-1:0]      err_count,
  output logic [ERR_W-1:0]      match_count,
  output logic [1:0]            state_o
`ifdef CODECHECK_ERR_CAPTURE_EN
  ,
  output logic                  cap_valid,
  output logic [DATA_WIDTH-1:0] cap_expected,
  output logic [DATA_WIDTH-1:0] cap_data
`endif
);

  localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W = $clog2(LOSS_CNT + 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] expected_q, expected_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic [MISS_W-1:0]     miss_q, miss_d;
  logic [ERR_W-1:0]      err_count_q, err_count_d;
  logic [ERR_W-1:0]      match_count_q, match_count_d;
  logic                  err_pulse_q, err_pulse_d;

  logic [DATA_WIDTH-1:0] next_of_data;
  logic [DATA_WIDTH-1:0] next_of_expected;
  logic                  hit;
  logic [RUN_W-1:0]      run_inc;
  logic                  lock_reached;
  logic [MISS_W-1:0]     miss_inc;
  logic                  loss_reached;

  // Resync target in HUNT: the word after the one just received.
  codegen_next #(
    .DATA_WIDTH (DATA_WIDTH),
    .STEP       (STEP)
  ) u_next_data (
    .x_i     (data),
    .limit_i (limit),
    .next_o  (next_of_data)
  );

  // Flywheel target in LOCKED: the word after the one we expected.
  codegen_next #(
    .DATA_WIDTH (DATA_WIDTH),
    .STEP       (STEP)
  ) u_next_expected (
    .x_i     (expected_q),
    .limit_i (limit),
    .next_o  (next_of_expected)
  );

  // Compare and run-length arithmetic shared by the FSM and the datapath.
  always_comb begin
    hit          = (data == expected_q);
    // The first word after entering HUNT (run 0) or a miss restarts the run at 1.
    run_inc      = ((run_q == '0) || !hit) ? RUN_W'(1) : run_q + RUN_W'(1);
    lock_reached = (run_inc == RUN_W'(LOCK_CNT));
    miss_inc     = miss_q + MISS_W'(1);
    loss_reached = (miss_inc == MISS_W'(LOSS_CNT));
  end

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a low enable forces IDLE from any state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = HUNT;
        HUNT:    if (valid && lock_reached) state_d = LOCKED;
        LOCKED:  if (valid && !hit && loss_reached) state_d = LOST;
        LOST:    state_d = HUNT;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM-derived outputs and registered status.
  always_comb begin
    locked      = (state_q == LOCKED);
    state_o     = state_q;
    err_pulse   = err_pulse_q;
    err_count   = err_count_q;
    match_count = match_count_q;
  end

  // Datapath next values: expected word, run lengths and saturating counters.
  always_comb begin
    expected_d    = expected_q;
    run_d         = run_q;
    miss_d        = miss_q;
    err_count_d   = err_count_q;
    match_count_d = match_count_q;
    err_pulse_d   = 1'b0;
    if (!enable) begin
      // Disable wins over any simultaneous compare: no pulse, no count.
      expected_d    = '0;
      run_d         = '0;
      miss_d        = '0;
      err_count_d   = '0;
      match_count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          run_d  = '0;
          miss_d = '0;
        end
        HUNT: begin
          if (valid) begin
            expected_d = next_of_data;
            run_d      = run_inc;
            miss_d     = '0;
          end
        end
        LOCKED: begin
          if (valid) begin
            expected_d = next_of_expected;
            if (hit) begin
              miss_d = '0;
              if (match_count_q != '1) match_count_d = match_count_q + ERR_W'(1);
            end else begin
              err_pulse_d = 1'b1;
              miss_d      = miss_inc;
              if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
            end
          end
        end
        LOST: begin
          run_d  = '0;
          miss_d = '0;
        end
        default: begin
          run_d  = '0;
          miss_d = '0;
        end
      endcase
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      expected_q    <= '0;
      run_q         <= '0;
      miss_q        <= '0;
      err_count_q   <= '0;
      match_count_q <= '0;
      err_pulse_q   <= 1'b0;
    end else begin
      expected_q    <= expected_d;
      run_q         <= run_d;
      miss_q        <= miss_d;
      err_count_q   <= err_count_d;
      match_count_q <= match_count_d;
      err_pulse_q   <= err_pulse_d;
    end
  end

`ifdef CODECHECK_ERR_CAPTURE_EN
  logic                  cap_valid_q, cap_valid_d;
  logic [DATA_WIDTH-1:0] cap_expected_q, cap_expected_d;
  logic [DATA_WIDTH-1:0] cap_data_q, cap_data_d;

  // Latch the first locked mismatch only; later misses leave it untouched.
  always_comb begin
    cap_valid_d    = cap_valid_q;
    cap_expected_d = cap_expected_q;
    cap_data_d     = cap_data_q;
    if (!enable) begin
      cap_valid_d    = 1'b0;
      cap_expected_d = '0;
      cap_data_d     = '0;
    end else if ((state_q == LOCKED) && valid && !hit && !cap_valid_q) begin
      cap_valid_d    = 1'b1;
      cap_expected_d = expected_q;
      cap_data_d     = data;
    end
  end

  // Capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid_q    <= 1'b0;
      cap_expected_q <= '0;
      cap_data_q     <= '0;
    end else begin
      cap_valid_q    <= cap_valid_d;
      cap_expected_q <= cap_expected_d;
      cap_data_q     <= cap_data_d;
    end
  end

  // Drive capture outputs straight from their registers.
  always_comb begin
    cap_valid    = cap_valid_q;
    cap_expected = cap_expected_q;
    cap_data     = cap_data_q;
  end
`endif

endmodule
